// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with two line buffers; the line length is learned from eol_in.
// Optional CONV3X3_ROUND_SAT_EN: round half-up before the shift and clamp to [0, 2^OUT_W-1].
module conv3x3_stream #(
   parameter int unsigned DATA_W   = 10,
   parameter int unsigned COEF_W   = 10,
   parameter int unsigned MAX_LINE = 1024,
   parameter int unsigned OUT_W    = 12,
   parameter int unsigned SHIFT    = 0
) (
   input  logic                       clk,
   input  logic                       aclr,
   input  logic                       data_valid_in,
   input  logic                       sof_in,
   input  logic                       eol_in,
   input  logic [DATA_W-1:0]          data,
   input  logic [9*COEF_W-1:0]        coef,
   output logic                       data_valid_out,
   output logic                       sof_out,
   output logic                       eol_out,
   output logic [OUT_W-1:0]           result,
   output logic [$clog2(MAX_LINE):0]  line_len,
   output logic                       err_overflow
);
   localparam int unsigned AW     = $clog2(MAX_LINE);
   localparam int unsigned CW     = AW + 1;
   localparam int unsigned PROD_W = DATA_W + COEF_W + 1;
   localparam int unsigned ACC_W  = DATA_W + COEF_W + 5;

   logic [CW-1:0]            col_q, col_cur;
   logic [1:0]               row_q, row_cur;
   logic                     in_frame_q, drop_q;
   logic                     accept, close_drop, win_ok, overflow;
   logic signed [COEF_W-1:0] coef_q [9];
   logic [DATA_W-1:0]        lb0_q [MAX_LINE];
   logic [DATA_W-1:0]        lb1_q [MAX_LINE];
   logic [DATA_W-1:0]        lb0_rd, lb1_rd;
   logic [AW-1:0]            idx;
   logic [DATA_W-1:0]        win_q [9];
   logic                     v1_q, s1_q, e1_q, v2_q, s2_q, e2_q, v3_q, s3_q, e3_q;
   logic signed [PROD_W-1:0] prod_d [9];
   logic signed [PROD_W-1:0] prod_q [9];
   logic signed [ACC_W-1:0]  sum_d, sum_q;
   logic [OUT_W-1:0]         result_d;

   // sof_in restarts the frame on the same pixel, so position is taken as (0,0) right away
   always_comb begin
      col_cur    = sof_in ? '0 : col_q;
      row_cur    = sof_in ? '0 : row_q;
      accept     = data_valid_in && (sof_in || (in_frame_q && !drop_q));
      close_drop = data_valid_in && !sof_in && in_frame_q && drop_q && eol_in;
      win_ok     = accept && (row_cur >= 2'd2) && (col_cur >= CW'(2));
      overflow   = accept && !eol_in && (col_cur == CW'(MAX_LINE - 1));
   end

   assign idx    = col_cur[AW-1:0];
   assign lb0_rd = lb0_q[idx];
   assign lb1_rd = lb1_q[idx];

   always_ff @(posedge clk) begin
      if (!aclr) begin
         col_q        <= '0;
         row_q        <= '0;
         in_frame_q   <= 1'b0;
         drop_q       <= 1'b0;
         line_len     <= '0;
         err_overflow <= 1'b0;
         for (int k = 0; k < 9; k++) coef_q[k] <= '0;
      end else begin
         if (accept && sof_in) begin
            in_frame_q <= 1'b1;
            drop_q     <= 1'b0;
            row_q      <= row_cur;
            for (int k = 0; k < 9; k++) coef_q[k] <= coef[k*COEF_W +: COEF_W];
         end
         if (accept || close_drop) begin
            if (eol_in) begin
               line_len <= col_cur + 1'b1;
               col_q    <= '0;
               row_q    <= (row_cur == 2'd3) ? 2'd3 : row_cur + 2'd1;
               drop_q   <= 1'b0;
            end else if (overflow) begin
               // col parks on the last slot; the eol that ends the drop reports MAX_LINE
               err_overflow <= 1'b1;
               drop_q       <= 1'b1;
               col_q        <= col_cur;
            end else begin
               col_q <= col_cur + 1'b1;
            end
         end
      end
   end

   // Line buffers read-before-write: LB0 holds the previous line, LB1 the one before it
   always_ff @(posedge clk) begin
      if (accept) begin
         lb0_q[idx] <= data;
         lb1_q[idx] <= lb0_rd;
         for (int r = 0; r < 3; r++) begin
            win_q[3*r]   <= win_q[3*r+1];
            win_q[3*r+1] <= win_q[3*r+2];
         end
         win_q[2] <= lb1_rd;
         win_q[5] <= lb0_rd;
         win_q[8] <= data;
      end
   end

   always_comb begin
      for (int k = 0; k < 9; k++) begin
         prod_d[k] = PROD_W'($signed({1'b0, win_q[k]})) * PROD_W'(coef_q[k]);
      end
      sum_d = '0;
      for (int k = 0; k < 9; k++) sum_d = sum_d + ACC_W'(prod_q[k]);
   end

`ifdef CONV3X3_ROUND_SAT_EN
   localparam logic signed [ACC_W-1:0] RND = ACC_W'((64'd1 << SHIFT) >> 1);
   logic signed [ACC_W-1:0] shifted;

   always_comb begin
      shifted = (sum_q + RND) >>> SHIFT;
      if (shifted[ACC_W-1]) begin
         result_d = '0;
      end else if (|shifted[ACC_W-2:OUT_W]) begin
         result_d = '1;
      end else begin
         result_d = shifted[OUT_W-1:0];
      end
   end
`else
   always_comb begin
      result_d = OUT_W'(sum_q >>> SHIFT);
   end
`endif

   always_ff @(posedge clk) begin
      if (!aclr) begin
         {v1_q, s1_q, e1_q, v2_q, s2_q, e2_q, v3_q, s3_q, e3_q} <= '0;
         for (int k = 0; k < 9; k++) prod_q[k] <= '0;
         sum_q          <= '0;
         data_valid_out <= 1'b0;
         sof_out        <= 1'b0;
         eol_out        <= 1'b0;
         result         <= '0;
      end else begin
         v1_q <= win_ok;
         s1_q <= win_ok && (row_cur == 2'd2) && (col_cur == CW'(2));
         e1_q <= win_ok && eol_in;
         for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
         {v2_q, s2_q, e2_q} <= {v1_q, s1_q, e1_q};
         sum_q <= sum_d;
         {v3_q, s3_q, e3_q} <= {v2_q, s2_q, e2_q};
         result         <= result_d;
         data_valid_out <= v3_q;
         sof_out        <= s3_q;
         eol_out        <= e3_q;
      end
   end

endmodule
